// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
// Instruction-fetch stage with a decoupling queue. Generates the fetch PC,
// issues reads to a synchronous 1-cycle-latency instruction memory, buffers
// the returned instruction with its PC and PC+4, and hands entries to decode
// over a valid/ready handshake. A redirect flushes the queue, drops any
// in-flight read and restarts fetch at the new target.
//
// Ports
//   IF_CLK            in   clock, rising edge
//   IF_RESET          in   asynchronous, active-high reset
//   REDIRECT_VALID    in   redirect fetch this cycle (highest priority)
//   REDIRECT_PC       in   redirect target, bits [1:0] ignored
//   IMEM_REQ          out  read request this cycle
//   IMEM_ADDR         out  read address (fetch PC)
//   IMEM_DATA         in   read data, one cycle after the request
//   DEC_VALID         out  queue head valid
//   DEC_READY         in   decode accepts head
//   DEC_INSTR         out  head instruction
//   DEC_PC            out  head PC
//   DEC_PC_PLUS_FOUR  out  head PC + 4
//   QUEUE_COUNT       out  current occupancy
module fetch_queue_stage #(
  parameter int              XLEN         = 32,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                     IF_CLK,
  input  logic                     IF_RESET,
  input  logic                     REDIRECT_VALID,
  input  logic [XLEN-1:0]          REDIRECT_PC,
  output logic                     IMEM_REQ,
  output logic [XLEN-1:0]          IMEM_ADDR,
  input  logic [XLEN-1:0]          IMEM_DATA,
  output logic                     DEC_VALID,
  input  logic                     DEC_READY,
  output logic [XLEN-1:0]          DEC_INSTR,
  output logic [XLEN-1:0]          DEC_PC,
  output logic [XLEN-1:0]          DEC_PC_PLUS_FOUR,
  output logic [$clog2(DEPTH):0]   QUEUE_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);
  localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] r_instr_q [DEPTH];
  logic [XLEN-1:0] r_pc_q    [DEPTH];
  logic [XLEN-1:0] r_pc4_q   [DEPTH];

  logic            w_dec_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [CW:0]     w_occ;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_dec_valid   = (r_count != '0);
  assign w_pop         = w_dec_valid & DEC_READY & ~REDIRECT_VALID;
  assign w_push        = r_inflight & ~REDIRECT_VALID;
  assign w_redirect_pc = REDIRECT_PC & ALIGN_MSK;

  // Entries held plus the one still in flight, crediting a same-cycle pop,
  // so issue resumes in the very cycle decode frees a slot.
  assign w_occ   = {1'b0, r_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
  assign w_issue = ~IF_RESET & ~REDIRECT_VALID & (w_occ < DEPTH_LIM);

  assign IMEM_REQ  = w_issue;
  assign IMEM_ADDR = r_fetch_pc;

  always_ff @(posedge IF_CLK or posedge IF_RESET) begin
    if (IF_RESET) begin
      r_fetch_pc    <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (REDIRECT_VALID) begin
      // Clearing the flag drops the response that arrives this cycle.
      r_fetch_pc    <= w_redirect_pc;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_STEP;
      end
    end
  end

  always_ff @(posedge IF_CLK or posedge IF_RESET) begin
    if (IF_RESET) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (REDIRECT_VALID) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is reset so the decode outputs read as zero out of reset.
  always_ff @(posedge IF_CLK or posedge IF_RESET) begin
    if (IF_RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
        r_pc4_q[i]   <= '0;
      end
    end else if (w_push) begin
      r_instr_q[r_wr_ptr] <= IMEM_DATA;
      r_pc_q[r_wr_ptr]    <= r_inflight_pc;
      r_pc4_q[r_wr_ptr]   <= r_inflight_pc + PC_STEP;
    end
  end

  assign DEC_VALID        = w_dec_valid;
  assign DEC_INSTR        = r_instr_q[r_rd_ptr];
  assign DEC_PC           = r_pc_q[r_rd_ptr];
  assign DEC_PC_PLUS_FOUR = r_pc4_q[r_rd_ptr];
  assign QUEUE_COUNT      = r_count;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb_fetch_queue_stage
// Bench for fetch_queue_stage: instruction memory model returning
// addr ^ 0xA5A5_0000, a scoreboard of expected decode entries, a per-cycle
// vector table for the fill/drain/redirect sequence, and directed
// sequences for PC wrap and an asynchronous reset pulse.
module tb_fetch_queue_stage;

  localparam int          XLEN = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV = 32'h0000_0100;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        IF_CLK;
  logic        IF_RESET;
  logic        REDIRECT_VALID;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic        DEC_VALID;
  logic        DEC_READY;
  logic [31:0] DEC_INSTR;
  logic [31:0] DEC_PC;
  logic [31:0] DEC_PC_PLUS_FOUR;
  logic [2:0]  QUEUE_COUNT;

  fetch_queue_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .IF_CLK(IF_CLK),
    .IF_RESET(IF_RESET),
    .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_PC(REDIRECT_PC),
    .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR),
    .IMEM_DATA(IMEM_DATA),
    .DEC_VALID(DEC_VALID),
    .DEC_READY(DEC_READY),
    .DEC_INSTR(DEC_INSTR),
    .DEC_PC(DEC_PC),
    .DEC_PC_PLUS_FOUR(DEC_PC_PLUS_FOUR),
    .QUEUE_COUNT(QUEUE_COUNT)
  );

  initial IF_CLK = 1'b0;
  always #5 IF_CLK = ~IF_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: request seen mid-cycle, data presented just after the edge.
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  always @(negedge IF_CLK) begin
    mem_pend = IMEM_REQ;
    mem_addr = IMEM_ADDR;
  end
  always @(posedge IF_CLK) begin
    #1;
    IMEM_DATA = mem_pend ? (mem_addr ^ XORK) : 32'h0BAD_0BAD;
  end

  // Scoreboard: every accepted request becomes an expected decode entry;
  // a redirect or reset throws away everything not yet consumed.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic        hold = 1'b0;
  logic [31:0] held_instr;
  logic [31:0] held_pc;

  always @(posedge IF_RESET) begin
    exp_q.delete();
    hold = 1'b0;
  end

  always @(negedge IF_CLK) begin
    exp_t e;
    if (IF_RESET) begin
      exp_q.delete();
      hold = 1'b0;
    end else if (REDIRECT_VALID) begin
      check("redirect_no_req", 32'(IMEM_REQ), 32'd0);
      exp_q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", 32'(DEC_VALID), 32'd1);
        check("stall_instr", DEC_INSTR, held_instr);
        check("stall_pc", DEC_PC, held_pc);
      end
      hold       = DEC_VALID & ~DEC_READY;
      held_instr = DEC_INSTR;
      held_pc    = DEC_PC;
      if (DEC_VALID && DEC_READY) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow actual_pc=%h required=no_entry at %0t", DEC_PC, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", DEC_INSTR, e.instr);
          check("sb_pc", DEC_PC, e.pc);
          check("sb_pc4", DEC_PC_PLUS_FOUR, e.pc4);
        end
      end
      if (IMEM_REQ) begin
        e.instr = IMEM_ADDR ^ XORK;
        e.pc    = IMEM_ADDR;
        e.pc4   = IMEM_ADDR + 32'd4;
        exp_q.push_back(e);
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  qc;
    logic        vld;
    logic [31:0] dpc;
  } vec_t;

  function automatic vec_t row(input logic rdy, input logic redir, input logic [31:0] rpc,
                               input logic req, input logic [31:0] addr, input logic [2:0] qc,
                               input logic vld, input logic [31:0] dpc);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.req = req;
    v.addr = addr; v.qc = qc; v.vld = vld; v.dpc = dpc;
    return v;
  endfunction

  vec_t tbl[22];

  task automatic step();
    @(posedge IF_CLK);
    #2;
  endtask

  task automatic mid();
    @(negedge IF_CLK);
    #1;
  endtask

  initial begin
    IF_RESET       = 1'b1;
    REDIRECT_VALID = 1'b0;
    REDIRECT_PC    = '0;
    DEC_READY      = 1'b0;
    IMEM_DATA      = '0;

    // Cycle 0 is the cycle reset is released. Rows 0-9 stall decode until
    // the queue fills; 10-14 drain at full rate; 15 redirects to 0x2003
    // with 3 queued and one in flight; 20 redirects together with a pop.
    tbl[0]  = row(1'b0, 1'b0, 32'h0,    1'b1, 32'h100,  3'd0, 1'b0, 32'h0);
    tbl[1]  = row(1'b0, 1'b0, 32'h0,    1'b1, 32'h104,  3'd0, 1'b0, 32'h0);
    tbl[2]  = row(1'b0, 1'b0, 32'h0,    1'b1, 32'h108,  3'd1, 1'b1, 32'h100);
    tbl[3]  = row(1'b0, 1'b0, 32'h0,    1'b1, 32'h10C,  3'd2, 1'b1, 32'h100);
    tbl[4]  = row(1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    3'd3, 1'b1, 32'h100);
    for (int i = 5; i < 10; i++)
      tbl[i] = row(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    3'd4, 1'b1, 32'h100);
    tbl[10] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h110,  3'd4, 1'b1, 32'h100);
    tbl[11] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h114,  3'd3, 1'b1, 32'h104);
    tbl[12] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h118,  3'd3, 1'b1, 32'h108);
    tbl[13] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h11C,  3'd3, 1'b1, 32'h10C);
    tbl[14] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h120,  3'd3, 1'b1, 32'h110);
    tbl[15] = row(1'b0, 1'b1, 32'h2003, 1'b0, 32'h0,    3'd3, 1'b1, 32'h114);
    tbl[16] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h2000, 3'd0, 1'b0, 32'h0);
    tbl[17] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h2004, 3'd0, 1'b0, 32'h0);
    tbl[18] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h2008, 3'd1, 1'b1, 32'h2000);
    tbl[19] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h200C, 3'd1, 1'b1, 32'h2004);
    tbl[20] = row(1'b1, 1'b1, 32'h3000, 1'b0, 32'h0,    3'd1, 1'b1, 32'h2008);
    tbl[21] = row(1'b1, 1'b0, 32'h0,    1'b1, 32'h3000, 3'd0, 1'b0, 32'h0);

    repeat (2) @(posedge IF_CLK);
    #1;
    check("rst_valid", 32'(DEC_VALID), 32'd0);
    check("rst_count", 32'(QUEUE_COUNT), 32'd0);
    check("rst_req", 32'(IMEM_REQ), 32'd0);
    check("rst_addr", IMEM_ADDR, RV);
    check("rst_instr", DEC_INSTR, 32'd0);
    check("rst_pc", DEC_PC, 32'd0);
    check("rst_pc4", DEC_PC_PLUS_FOUR, 32'd0);

    step();
    IF_RESET = 1'b0;
    for (int i = 0; i < 22; i++) begin
      DEC_READY      = tbl[i].rdy;
      REDIRECT_VALID = tbl[i].redir;
      REDIRECT_PC    = tbl[i].rpc;
      mid();
      check($sformatf("row%0d_req", i), 32'(IMEM_REQ), 32'(tbl[i].req));
      if (tbl[i].req) check($sformatf("row%0d_addr", i), IMEM_ADDR, tbl[i].addr);
      check($sformatf("row%0d_count", i), 32'(QUEUE_COUNT), 32'(tbl[i].qc));
      check($sformatf("row%0d_valid", i), 32'(DEC_VALID), 32'(tbl[i].vld));
      if (tbl[i].vld) check($sformatf("row%0d_pc", i), DEC_PC, tbl[i].dpc);
      step();
    end
    REDIRECT_VALID = 1'b0;

    // Random decode back-pressure with occasional redirects.
    for (int i = 0; i < 150; i++) begin
      DEC_READY      = 1'($urandom_range(0, 1));
      REDIRECT_VALID = ($urandom_range(0, 15) == 0);
      REDIRECT_PC    = $urandom;
      step();
    end
    REDIRECT_VALID = 1'b0;

    // PC wrap from the top of the address space.
    DEC_READY      = 1'b0;
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = 32'hFFFF_FFFE;
    step();
    REDIRECT_VALID = 1'b0;
    mid();
    check("wrap_req0", 32'(IMEM_REQ), 32'd1);
    check("wrap_addr0", IMEM_ADDR, 32'hFFFF_FFFC);
    check("wrap_count0", 32'(QUEUE_COUNT), 32'd0);
    step();
    mid();
    check("wrap_req1", 32'(IMEM_REQ), 32'd1);
    check("wrap_addr1", IMEM_ADDR, 32'h0000_0000);
    step();
    mid();
    check("wrap_valid", 32'(DEC_VALID), 32'd1);
    check("wrap_pc", DEC_PC, 32'hFFFF_FFFC);
    check("wrap_pc4", DEC_PC_PLUS_FOUR, 32'h0000_0000);
    check("wrap_instr", DEC_INSTR, 32'h5A5A_FFFC);
    step();
    DEC_READY = 1'b1;
    repeat (8) step();

    // Asynchronous reset pulse between edges, mid-stream.
    @(negedge IF_CLK);
    #3;
    IF_RESET = 1'b1;
    #1;
    check("arst_valid", 32'(DEC_VALID), 32'd0);
    check("arst_count", 32'(QUEUE_COUNT), 32'd0);
    check("arst_req", 32'(IMEM_REQ), 32'd0);
    check("arst_instr", DEC_INSTR, 32'd0);
    check("arst_pc", DEC_PC, 32'd0);
    check("arst_pc4", DEC_PC_PLUS_FOUR, 32'd0);
    step();
    IF_RESET = 1'b0;
    mid();
    check("arst_c0_req", 32'(IMEM_REQ), 32'd1);
    check("arst_c0_addr", IMEM_ADDR, RV);
    check("arst_c0_valid", 32'(DEC_VALID), 32'd0);
    step();
    mid();
    check("arst_c1_valid", 32'(DEC_VALID), 32'd0);
    step();
    mid();
    check("arst_c2_valid", 32'(DEC_VALID), 32'd1);
    check("arst_c2_pc", DEC_PC, RV);
    check("arst_c2_pc4", DEC_PC_PLUS_FOUR, RV + 32'd4);
    step();
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
# fetch_queue_stage

Parametrised instruction-fetch stage with a decoupling queue. It generates the fetch PC and issues reads to a synchronous, 1-cycle-latency instruction memory. Returned instructions are buffered with their PC and PC+4 in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. A single redirect port (branch, jump or trap target, muxed upstream) flushes the queue, discards any in-flight read, and restarts fetch at the new target.

## Interface
- XLEN, 32, address/instruction width; ≥ 32.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- RESET_VECTOR, 0, PC after reset; low 2 bits must be 0.

Ports:
- IF_CLK  in  1  sole clock, rising edge.
- IF_RESET  in  1  asynchronous, active-high reset.
- REDIRECT_VALID  in  1  redirect fetch this cycle.
- REDIRECT_PC  in  XLEN  redirect target; bits [1:0] ignored and treated as 0.
- IMEM_REQ  out  1  read request this cycle (combinational).
- IMEM_ADDR  out  XLEN  read address, equal to the fetch PC register (combinational).
- IMEM_DATA  in  XLEN  read data, valid the cycle after the accepted request.
- DEC_VALID  out  1  queue head valid.
- DEC_READY  in  1  decode accepts head.
- DEC_INSTR  out  XLEN  head instruction.
- DEC_PC  out  XLEN  head PC.
- DEC_PC_PLUS_FOUR  out  XLEN  head PC + 4.
- QUEUE_COUNT  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State: fetch_pc, in-flight flag and in-flight PC, FIFO (rd/wr pointers plus count).
- pop = DEC_VALID & DEC_READY & !REDIRECT_VALID.
- Issue condition: IMEM_REQ = !IF_RESET & !REDIRECT_VALID & (count + inflight − pop < DEPTH).
  - The same-cycle pop is credited when computing free space.
- On issue:
  - in-flight flag ← 1, in-flight PC ← fetch_pc.
  - fetch_pc ← fetch_pc + 4, modulo 2^XLEN (wraps from all-ones-minus-3 to 0).
- No issue: in-flight flag ← 0.
- Push: when the in-flight flag is 1 and REDIRECT_VALID is 0, write {IMEM_DATA, in-flight PC, in-flight PC+4} at the FIFO tail.
  - A push can never overflow, because issue reserved the space.
- Simultaneous push and pop: count unchanged, and both pointers advance.
- Redirect (highest priority), on the next edge:
  - fetch_pc ← {REDIRECT_PC[XLEN-1:2], 2'b00}.
  - FIFO emptied (pointers and count to 0).
  - In-flight flag ← 0, so the response arriving that cycle is dropped.
  - No issue and no pop occur in the redirect cycle.
- DEC_* outputs are driven from the FIFO head and are valid only while DEC_VALID = 1.
- DEC_VALID = (count ≠ 0), registered-equivalent: there is no combinational path from IMEM_DATA to DEC_*.
- While DEC_VALID = 1 and DEC_READY = 0, DEC_* hold stable.

## Timing
- Reset values: fetch_pc = RESET_VECTOR; count = 0; in-flight flag = 0; DEC_VALID = 0; QUEUE_COUNT = 0; IMEM_REQ = 0 while IF_RESET is high.
- DEC_INSTR/DEC_PC/DEC_PC_PLUS_FOUR are 0 after reset.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Any in-flight read is forgotten.
- Fetch-to-decode latency:
  - Request in cycle N.
  - Data captured at the end of cycle N+1.
  - DEC_VALID in cycle N+2.
- After reset release, the first request is issued in cycle 0 at RESET_VECTOR, and DEC_VALID rises in cycle 2.
- Redirect asserted in cycle R:
  - DEC_VALID = 0 in cycle R+1.
  - Target requested in R+1.
  - Target instruction at decode in R+3.
- Throughput: 1 instruction/cycle sustained with DEC_READY held high, for any DEPTH ≥ 2.
- Full: count = DEPTH, or count + inflight = DEPTH without a pop → IMEM_REQ = 0. Issue resumes in the same cycle as a pop.
- Empty with DEC_READY = 1: no pop, DEC_VALID = 0.

## Test plan
- Reset, RESET_VECTOR = 0x100, IMEM returns addr^0xA5A5_0000, DEC_READY = 1:
  - DEC_VALID first high in cycle 2 with DEC_PC = 0x100 and DEC_PC_PLUS_FOUR = 0x104.
  - Then one instruction per cycle with DEC_PC incrementing by 4.
- DEPTH = 4, DEC_READY = 0 for 10 cycles:
  - Exactly 4 requests are issued; QUEUE_COUNT = 4; IMEM_REQ stays 0.
  - On DEC_READY = 1, entries drain in order, and a new request issues in the same cycle as the first pop.
- Redirect to 0x2003 while the queue holds 3 entries and a read is in flight:
  - Next cycle: QUEUE_COUNT = 0, DEC_VALID = 0.
  - IMEM_ADDR = 0x2000 requested that cycle; the next DEC_PC is 0x2000, appearing 3 cycles after the redirect.
  - The stale response is never presented.
- Redirect and pop asserted in the same cycle:
  - The pop is ignored (the head is not consumed) and the flush takes effect.
  - DEC_READY toggling randomly afterwards produces no duplicates or gaps.
- fetch_pc = 0xFFFF_FFFC: requests FFFF_FFFC then 0000_0000; DEC_PC_PLUS_FOUR for the first entry = 0.
- IF_RESET pulsed asynchronously (between edges) mid-stream: outputs clear immediately, and fetch restarts at RESET_VECTOR with the 2-cycle latency.
